// File: rtl/mil1553_word_encoder_if.sv
// Word-source side of the 1553 encoder: start strobes and word in, serial line and status out.
// A start is taken on the rising edge where tx_busy=0 and tx_csw|tx_dw=1; strobes while busy are dropped.
interface mil1553_word_encoder_if;
   logic [15:0] tx_dword;
   logic        tx_csw;
   logic        tx_dw;
   logic        tx_busy;
   logic        tx_data;
   logic        tx_dval;
   logic        fetch_next;
   logic [1:0]  state_dbg;

   modport master (
      output tx_dword, tx_csw, tx_dw,
      input  tx_busy, tx_data, tx_dval, fetch_next, state_dbg
   );

   modport slave (
      input  tx_dword, tx_csw, tx_dw,
      output tx_busy, tx_data, tx_dval, fetch_next, state_dbg
   );
endinterface

// File: rtl/mil1553_word_encoder.sv
// MIL-STD-1553B word transmitter: one 16-bit word -> 40 half-bit Manchester II frame
// (3-bit sync, 16 data bits MSB first, odd parity). One clk = one half-bit.
module mil1553_word_encoder (
   input  logic                   clk,
   input  logic                   rst_n,
   mil1553_word_encoder_if.slave  bus
);
   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] SYNC   = 2'd1;
   localparam logic [1:0] DATA   = 2'd2;
   localparam logic [1:0] PARITY = 2'd3;

   localparam logic [5:0] SYNC_MID     = 6'd3;
   localparam logic [5:0] SYNC_END     = 6'd6;
   localparam logic [5:0] PARITY_START = 6'd38;
   localparam logic [5:0] LAST_HALF    = 6'd39;

   logic [1:0]  state;
   logic [5:0]  cnt;
   logic [16:0] shreg;
   logic        sync_csw;
   logic        busy_q;
   logic        data_q;
   logic        dval_q;
   logic        fetch_q;

   logic        start;
   logic [5:0]  cnt_nx;
   logic        half_nx;
   logic        shift_nx;
   logic [1:0]  state_nx;

   // cnt is the index of the half-bit currently on the line; the next one is
   // computed here so every output stays a plain register.
   always_comb begin
      start    = ~busy_q & (bus.tx_csw | bus.tx_dw);
      cnt_nx   = cnt + 6'd1;
      half_nx  = 1'b0;
      shift_nx = 1'b0;
      state_nx = SYNC;
      if (cnt_nx < SYNC_END) begin
         half_nx  = sync_csw ? (cnt_nx < SYNC_MID) : (cnt_nx >= SYNC_MID);
         state_nx = SYNC;
      end else begin
         // Even index = first half (true bit), odd = second half (inverted), then advance.
         half_nx  = cnt_nx[0] ? ~shreg[16] : shreg[16];
         shift_nx = cnt_nx[0];
         state_nx = (cnt_nx >= PARITY_START) ? PARITY : DATA;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= 6'd0;
         shreg    <= 17'd0;
         sync_csw <= 1'b0;
         busy_q   <= 1'b0;
         data_q   <= 1'b0;
         dval_q   <= 1'b0;
         fetch_q  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state    <= SYNC;
                  cnt      <= 6'd0;
                  shreg    <= {bus.tx_dword, ~^bus.tx_dword};
                  sync_csw <= bus.tx_csw;
                  busy_q   <= 1'b1;
                  dval_q   <= 1'b1;
                  data_q   <= bus.tx_csw;
                  fetch_q  <= 1'b0;
               end
            end
            default: begin
               if (cnt == LAST_HALF) begin
                  state   <= IDLE;
                  busy_q  <= 1'b0;
                  dval_q  <= 1'b0;
                  data_q  <= 1'b0;
                  fetch_q <= 1'b0;
               end else begin
                  state   <= state_nx;
                  cnt     <= cnt_nx;
                  data_q  <= half_nx;
                  fetch_q <= (cnt_nx == LAST_HALF);
                  if (shift_nx) shreg <= {shreg[15:0], 1'b0};
               end
            end
         endcase
      end
   end

   assign bus.tx_busy    = busy_q;
   assign bus.tx_data    = data_q;
   assign bus.tx_dval    = dval_q;
   assign bus.fetch_next = fetch_q;
   assign bus.state_dbg  = state;
endmodule

// File: tb/tb_mil1553_word_encoder.sv
// Bench for mil1553_word_encoder: directed vector table, hand-written corner sequences,
// and random words checked against a frame model built from the Manchester rules.
`timescale 1ns/1ps
module tb_mil1553_word_encoder;
  logic clk;
  logic rst_n;
  int   n_compared;
  int   n_mismatched;
  logic [39:0] exp_q[$];

  mil1553_word_encoder_if bus ();

  mil1553_word_encoder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [15:0] dword;
    logic        csw;
    logic        dw;
    logic [39:0] exp_frame;
  } vec_t;

  vec_t vecs[6];

  // Reference model: sync pattern, then each of {data, odd parity} as a 10 / 01 pair; h0 at bit 39.
  function automatic logic [39:0] model_frame(logic [15:0] w, logic csw);
    logic [39:0] f;
    logic [16:0] seq;
    logic        par;
    par = ($countones(w) % 2 == 0);
    seq = {w, par};
    f[39:34] = csw ? 6'b111000 : 6'b000111;
    for (int i = 0; i < 17; i++)
      f[33 - 2*i -: 2] = seq[16 - i] ? 2'b10 : 2'b01;
    return f;
  endfunction

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] req);
    n_compared++;
    if (act !== req) begin
      n_mismatched++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic check_idle(input string name);
    check(name, {36'd0, bus.tx_busy, bus.tx_dval, bus.tx_data, bus.fetch_next}, 40'd0);
  endtask

  // Called at a negedge in an idle cycle; returns at the negedge of the first idle cycle after the frame.
  task automatic run_frame(input string name, input logic [15:0] w, input logic csw,
                           input logic dw, input int inject_at);
    logic [39:0] obs_data, obs_busy, obs_dval, obs_fetch, exp_f;
    bus.tx_dword = w;
    bus.tx_csw   = csw;
    bus.tx_dw    = dw;
    @(negedge clk);
    bus.tx_csw   = 1'b0;
    bus.tx_dw    = 1'b0;
    bus.tx_dword = 16'($urandom);
    for (int n = 0; n < 40; n++) begin
      obs_data[39-n]  = bus.tx_data;
      obs_busy[39-n]  = bus.tx_busy;
      obs_dval[39-n]  = bus.tx_dval;
      obs_fetch[39-n] = bus.fetch_next;
      bus.tx_dw = (n == inject_at);
      @(negedge clk);
    end
    bus.tx_dw = 1'b0;
    exp_f = exp_q.pop_front();
    check({name, " data"},  obs_data,  exp_f);
    check({name, " busy"},  obs_busy,  {40{1'b1}});
    check({name, " dval"},  obs_dval,  {40{1'b1}});
    check({name, " fetch"}, obs_fetch, 40'h1);
    check_idle({name, " end_idle"});
  endtask

  initial begin
    logic [39:0] any_busy;
    n_compared   = 0;
    n_mismatched = 0;
    vecs[0] = '{16'h5555, 1'b1, 1'b0, {6'b111000, 32'h6666_6666, 2'b10}};
    vecs[1] = '{16'hFFFF, 1'b0, 1'b1, {6'b000111, 32'hAAAA_AAAA, 2'b10}};
    vecs[2] = '{16'h1234, 1'b0, 1'b1, {6'b000111, 32'h5659_5A65, 2'b01}};
    vecs[3] = '{16'hABCD, 1'b1, 1'b0, {6'b111000, 32'h999A_A5A6, 2'b10}};
    vecs[4] = '{16'h0000, 1'b0, 1'b1, {6'b000111, 32'h5555_5555, 2'b10}};
    vecs[5] = '{16'h0F0F, 1'b1, 1'b1, {6'b111000, 32'h55AA_55AA, 2'b10}};

    // reset held: strobes must be ignored
    rst_n = 1'b0;
    bus.tx_dword = 16'hA5A5;
    bus.tx_csw = 1'b1;
    bus.tx_dw  = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_idle("reset_hold");
    end
    bus.tx_csw = 1'b0;
    bus.tx_dw  = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_idle("post_reset");

    // table vectors; entries 3 and 4 run back-to-back (DW strobe in the first idle cycle)
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(vecs[i].exp_frame);
      run_frame($sformatf("vec%0d", i), vecs[i].dword, vecs[i].csw, vecs[i].dw, -1);
      if (i != 3) @(negedge clk);
    end

    // DW strobe while busy: frame unchanged, nothing follows
    exp_q.push_back({6'b111000, 32'h5AA5_5AA5, 2'b10});
    run_frame("busy_strobe", 16'h3C3C, 1'b1, 1'b0, 10);
    any_busy = '0;
    for (int n = 0; n < 40; n++) begin
      any_busy[n] = bus.tx_busy | bus.tx_dval | bus.tx_data;
      @(negedge clk);
    end
    check("no_extra_frame", any_busy, 40'd0);

    // reset at h20 aborts immediately
    bus.tx_dword = 16'hBEEF;
    bus.tx_csw   = 1'b1;
    @(negedge clk);
    bus.tx_csw   = 1'b0;
    repeat (20) @(negedge clk);
    check("mid_busy", {39'd0, bus.tx_busy}, 40'd1);
    rst_n = 1'b0;
    #1;
    check_idle("async_abort");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    any_busy = '0;
    for (int n = 0; n < 40; n++) begin
      any_busy[n] = bus.tx_busy | bus.tx_dval | bus.tx_data | bus.fetch_next;
      @(negedge clk);
    end
    check("idle_after_abort", any_busy, 40'd0);

    // random words with random strobe type and gaps, including back-to-back
    for (int i = 0; i < 40; i++) begin
      logic [15:0] w;
      logic [1:0]  sel;
      int          gap;
      w   = 16'($urandom);
      sel = 2'($urandom_range(1, 3));
      gap = $urandom_range(0, 2);
      exp_q.push_back(model_frame(w, sel[1]));
      run_frame($sformatf("rand%0d", i), w, sel[1], sel[0], -1);
      repeat (gap) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end
endmodule
